// File: rtl/fp_mul_issue.sv
// FP multiply issue sequencer: 32x32 FP register file, operand/product
// handshakes to the multiplier, writeback, classification and hang recovery.
module fp_mul_issue #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_rs1,
  input  logic [4:0]  cmd_rs2,
  input  logic [4:0]  cmd_rd,
  input  logic        ld_en,
  input  logic [4:0]  ld_addr,
  input  logic [31:0] ld_data,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] mul_a,
  output logic        mul_a_stb,
  input  logic        mul_a_ack,
  output logic [31:0] mul_b,
  output logic        mul_b_stb,
  input  logic        mul_b_ack,
  input  logic [31:0] mul_z,
  input  logic        mul_z_stb,
  output logic        mul_z_ack,
  output logic        mul_rst_n,
  output logic        done,
  output logic [4:0]  done_rd,
  output logic [31:0] done_data,
  output logic        res_nan,
  output logic        res_inf,
  output logic        res_zero,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_Z,
    S_WB,
    S_FLUSH
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [31:0]      rf [32];
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [4:0]       rd;

  logic accept;
  logic cap_z;
  logic busy;
  logic expire;

  assign accept = (state == S_IDLE) && cmd_valid;
  assign cap_z  = (state == S_WAIT_Z) && mul_z_stb;
  assign busy   = (state == S_SEND_A) ||
                  (state == S_SEND_B) ||
                  (state == S_WAIT_Z);
  assign expire = busy && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nx    = state;
    cmd_ready   = 1'b0;
    mul_a_stb   = 1'b0;
    mul_b_stb   = 1'b0;
    mul_z_ack   = 1'b0;
    done        = 1'b0;
    timeout_err = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nx = S_SEND_A;
      end
      S_SEND_A: begin
        mul_a_stb = 1'b1;
        if (mul_a_ack) state_nx = S_SEND_B;
      end
      S_SEND_B: begin
        mul_b_stb = 1'b1;
        if (mul_b_ack) state_nx = S_WAIT_Z;
      end
      S_WAIT_Z: begin
        mul_z_ack = 1'b1;
        if (mul_z_stb) state_nx = S_WB;
      end
      S_WB: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_FLUSH: begin
        timeout_err = 1'b1;
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // a product landing on the expiry edge still completes
    if (expire && !cap_z) state_nx = S_FLUSH;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      done_rd   <= '0;
      done_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
      end
      if (cap_z) begin
        done_rd   <= rd;
        done_data <= mul_z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && accept) begin
      op_a <= rf[cmd_rs1];
      op_b <= rf[cmd_rs2];
      rd   <= cmd_rd;
    end
  end

  // writeback is last so it wins an address collision with the load port
  always_ff @(posedge clk) begin
    if (ld_en) rf[ld_addr] <= ld_data;
    if (reset_n && cap_z) rf[rd] <= mul_z;
  end

  assign dbg_data  = rf[dbg_addr];
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign mul_rst_n = reset_n & (state != S_FLUSH);

  logic [7:0]  res_exp;
  logic [22:0] res_man;

  assign res_exp  = done_data[30:23];
  assign res_man  = done_data[22:0];
  assign res_nan  = (res_exp == 8'hFF) && (res_man != '0);
  assign res_inf  = (res_exp == 8'hFF) && (res_man == '0);
  assign res_zero = (res_exp == 8'h00) && (res_man == '0);

endmodule

// File: tb/tb_fp_mul_issue.sv
// Bench for fp_mul_issue: handshake model of the multiplier plus a
// scoreboard of expected completions.
module tb_fp_mul_issue;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [4:0]  cmd_rs1 = '0;
  logic [4:0]  cmd_rs2 = '0;
  logic [4:0]  cmd_rd = '0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [31:0] mul_a;
  logic        mul_a_stb;
  logic        mul_a_ack = 1'b0;
  logic [31:0] mul_b;
  logic        mul_b_stb;
  logic        mul_b_ack = 1'b0;
  logic [31:0] mul_z = '0;
  logic        mul_z_stb = 1'b0;
  logic        mul_z_ack;
  logic        mul_rst_n;
  logic        done;
  logic [4:0]  done_rd;
  logic [31:0] done_data;
  logic        res_nan;
  logic        res_inf;
  logic        res_zero;
  logic        timeout_err;

  fp_mul_issue #(.TIMEOUT(TO), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .mul_a(mul_a), .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b(mul_b), .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .mul_rst_n(mul_rst_n),
    .done(done), .done_rd(done_rd), .done_data(done_data),
    .res_nan(res_nan), .res_inf(res_inf), .res_zero(res_zero),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  logic [31:0] shadow [32];
  logic [36:0] sb [$];

  // normal-number multiply, truncating
  function automatic logic [31:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
    if (p[47]) begin
      p = p >> 1;
      e = e + 10'd1;
    end
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  int          a_dly = 0;
  int          b_dly = 0;
  int          z_dly = 0;
  bit          b_never = 1'b0;
  bit          z_force = 1'b0;
  logic [31:0] z_val = '0;
  int          phase = 0;
  int          w = 0;
  logic [31:0] cap_a = '0;
  logic [31:0] cap_b = '0;
  logic [31:0] hold = '0;
  int          a_xf = 0;
  int          b_xf = 0;
  int          unstable = 0;

  always @(negedge clk) begin
    if (mul_rst_n !== 1'b1) begin
      phase = 0; w = 0;
      mul_a_ack = 1'b0; mul_b_ack = 1'b0; mul_z_stb = 1'b0;
    end else begin
      if (phase == 0 && mul_a_ack) begin
        a_xf++; mul_a_ack = 1'b0; phase = 1; w = 0;
      end
      if (phase == 0 && mul_a_stb) begin
        if (w == 0) hold = mul_a;
        else if (mul_a !== hold) unstable++;
        if (w >= a_dly) begin
          mul_a_ack = 1'b1; cap_a = mul_a;
        end else w++;
      end
      if (phase == 1 && mul_b_ack) begin
        b_xf++; mul_b_ack = 1'b0; phase = 2; w = 0;
      end
      if (phase == 1 && mul_b_stb && !b_never) begin
        if (w == 0) hold = mul_b;
        else if (mul_b !== hold) unstable++;
        if (w >= b_dly) begin
          mul_b_ack = 1'b1; cap_b = mul_b;
        end else w++;
      end
      if (phase == 2 && mul_z_stb) begin
        mul_z_stb = 1'b0; phase = 0; w = 0;
      end else if (phase == 2 && mul_z_ack) begin
        if (w >= z_dly) begin
          mul_z_stb = 1'b1;
          mul_z = z_force ? z_val : fmul(cap_a, cap_b);
        end else w++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
    shadow[a] = d;
  endtask

  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, output int acc);
    cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd; cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready; i++) tick();
    tick();
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset_n = 1'b0;
    tick(); tick();
    load(5'd1, 32'h4000_0000);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got rdy=%b done=%b to=%b want 1 0 0",
               cmd_ready, done, timeout_err);
    end
    checks++;
    if (done_rd !== 5'd0 || done_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_done got rd=%h data=%h want 0 0",
               done_rd, done_data);
    end
    checks++;
    if (mul_rst_n !== 1'b0 || mul_a_stb !== 1'b0 || mul_z_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mul got rst_n=%b astb=%b zack=%b want 0 0 0",
               mul_rst_n, mul_a_stb, mul_z_ack);
    end
    reset_n = 1'b1;
    tick();
    peek(5'd1, d);
    checks++;
    if (d !== 32'h4000_0000) begin
      errors++;
      $display("FAIL reset_load got %h want 40000000", d);
    end
  endtask

  task automatic test_basic();
    int acc;
    bit ok;
    int a0, b0;
    logic [36:0] e;
    logic [31:0] d;
    load(5'd2, 32'h4040_0000);
    a0 = a_xf; b0 = b_xf;
    issue(5'd1, 5'd2, 5'd3, acc);
    sb.push_back({5'd3, 32'h40C0_0000});
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done got none want pulse");
    end
    e = sb.pop_front();
    checks++;
    if (done_rd !== e[36:32] || done_data !== e[31:0]) begin
      errors++;
      $display("FAIL basic_data got %h/%h want %h/%h",
               done_rd, done_data, e[36:32], e[31:0]);
    end
    checks++;
    if ({res_nan, res_inf, res_zero} !== 3'b000) begin
      errors++;
      $display("FAIL basic_flags got %b want 000",
               {res_nan, res_inf, res_zero});
    end
    checks++;
    if (a_xf - a0 != 1 || b_xf - b0 != 1) begin
      errors++;
      $display("FAIL basic_xfers got a=%0d b=%0d want 1 1",
               a_xf - a0, b_xf - b0);
    end
    peek(5'd3, d);
    checks++;
    if (d !== 32'h40C0_0000) begin
      errors++;
      $display("FAIL basic_rf got %h want 40c00000", d);
    end
    tick();
    checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_pulse got done=%b rdy=%b want 0 1",
               done, cmd_ready);
    end
  endtask

  task automatic test_class();
    logic [31:0] vals [3];
    logic [2:0]  flg [3];
    int acc;
    bit ok;
    logic [36:0] e;
    vals[0] = 32'h7F80_0000; flg[0] = 3'b010;
    vals[1] = 32'h7FC0_0000; flg[1] = 3'b100;
    vals[2] = 32'h8000_0000; flg[2] = 3'b001;
    load(5'd4, 32'h7F80_0000);
    load(5'd5, 32'h3F80_0000);
    z_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      z_val = vals[i];
      issue(5'd4, 5'd5, 5'd6, acc);
      sb.push_back({5'd6, vals[i]});
      wait_done(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || done_data !== e[31:0]) begin
        errors++;
        $display("FAIL class_data[%0d] got %h want %h",
                 i, done_data, e[31:0]);
      end
      checks++;
      if ({res_nan, res_inf, res_zero} !== flg[i]) begin
        errors++;
        $display("FAIL class_flags[%0d] got %b want %b",
                 i, {res_nan, res_inf, res_zero}, flg[i]);
      end
      tick();
    end
    z_force = 1'b0;
  endtask

  task automatic test_timeout();
    int acc;
    int d0;
    bit seen;
    logic [31:0] d;
    load(5'd7, 32'hDEAD_BEEF);
    d0 = done_cnt;
    b_never = 1'b1;
    issue(5'd1, 5'd2, 5'd7, acc);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (timeout_err) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || cyc - acc != TO) begin
      errors++;
      $display("FAIL to_latency got seen=%b dt=%0d want 1 %0d",
               seen, cyc - acc, TO);
    end
    checks++;
    if (mul_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL to_mulrst got %b want 0", mul_rst_n);
    end
    tick();
    b_never = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || cmd_ready !== 1'b1 || mul_rst_n !== 1'b1) begin
      errors++;
      $display("FAIL to_after got to=%b rdy=%b rst_n=%b want 0 1 1",
               timeout_err, cmd_ready, mul_rst_n);
    end
    peek(5'd7, d);
    checks++;
    if (d !== 32'hDEAD_BEEF || done_cnt != d0) begin
      errors++;
      $display("FAIL to_nowb got rf=%h dn=%0d want deadbeef %0d",
               d, done_cnt - d0, 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] s1 [4];
    logic [4:0] s2 [4];
    logic [4:0] dd [4];
    int acc;
    int d0;
    bit ok;
    logic [36:0] e;
    load(5'd12, 32'h3FC0_0000);
    load(5'd13, 32'h4020_0000);
    load(5'd14, 32'hC040_0000);
    load(5'd15, 32'h3F40_0000);
    s1[0] = 5'd12; s2[0] = 5'd13; dd[0] = 5'd20;
    s1[1] = 5'd14; s2[1] = 5'd15; dd[1] = 5'd21;
    s1[2] = 5'd13; s2[2] = 5'd14; dd[2] = 5'd22;
    s1[3] = 5'd15; s2[3] = 5'd12; dd[3] = 5'd23;
    d0 = done_cnt;
    unstable = 0;
    for (int i = 0; i < 4; i++) begin
      a_dly = int'($urandom_range(0, 5));
      b_dly = int'($urandom_range(0, 5));
      z_dly = int'($urandom_range(0, 5));
      issue(s1[i], s2[i], dd[i], acc);
      sb.push_back({dd[i], fmul(shadow[s1[i]], shadow[s2[i]])});
      wait_done(ok);
      e = sb.pop_front();
      checks++;
      if (!ok || done_rd !== e[36:32] || done_data !== e[31:0]) begin
        errors++;
        $display("FAIL b2b[%0d] got %h/%h want %h/%h",
                 i, done_rd, done_data, e[36:32], e[31:0]);
      end
    end
    tick();
    a_dly = 0; b_dly = 0; z_dly = 0;
    checks++;
    if (unstable != 0 || done_cnt - d0 != 4) begin
      errors++;
      $display("FAIL b2b_misc got unstable=%0d dones=%0d want 0 4",
               unstable, done_cnt - d0);
    end
  endtask

  task automatic wb_collide(input logic [4:0] rd, input logic [4:0] la);
    int acc;
    bit ok;
    logic [36:0] e;
    z_dly = 2;
    issue(5'd1, 5'd2, rd, acc);
    sb.push_back({rd, 32'h40C0_0000});
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (mul_z_stb && mul_z_ack) begin
        ok = 1'b1;
        break;
      end
    end
    ld_en = 1'b1; ld_addr = la; ld_data = 32'h1234_5678;
    tick();
    ld_en = 1'b0;
    z_dly = 0;
    e = sb.pop_front();
    checks++;
    if (!ok || done !== 1'b1 || done_data !== e[31:0]) begin
      errors++;
      $display("FAIL coll_done got ok=%b done=%b data=%h want 1 1 %h",
               ok, done, done_data, e[31:0]);
    end
  endtask

  task automatic test_wb_collision();
    logic [31:0] d;
    wb_collide(5'd8, 5'd8);
    peek(5'd8, d);
    checks++;
    if (d !== 32'h40C0_0000) begin
      errors++;
      $display("FAIL coll_same got %h want 40c00000", d);
    end
    tick();
    load(5'd10, 32'h0);
    wb_collide(5'd9, 5'd10);
    peek(5'd9, d);
    checks++;
    if (d !== 32'h40C0_0000) begin
      errors++;
      $display("FAIL coll_diff_wb got %h want 40c00000", d);
    end
    peek(5'd10, d);
    checks++;
    if (d !== 32'h1234_5678) begin
      errors++;
      $display("FAIL coll_diff_ld got %h want 12345678", d);
    end
    tick();
  endtask

  task automatic test_reset_midop();
    int acc;
    int d0;
    bit ok;
    logic [31:0] d1, d2, d3;
    load(5'd11, 32'h1111_1111);
    z_dly = 20;
    issue(5'd1, 5'd2, 5'd11, acc);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mul_z_ack) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || mul_rst_n !== 1'b0) begin
      errors++;
      $display("FAIL rmid_mulrst got ok=%b rst_n=%b want 1 0", ok, mul_rst_n);
    end
    tick();
    reset_n = 1'b1;
    z_dly = 0;
    checks++;
    if (cmd_ready !== 1'b1 || mul_z_ack !== 1'b0 || done_data !== 32'd0) begin
      errors++;
      $display("FAIL rmid_state got rdy=%b zack=%b data=%h want 1 0 0",
               cmd_ready, mul_z_ack, done_data);
    end
    for (int i = 0; i < 10; i++) tick();
    peek(5'd11, d1);
    peek(5'd1, d2);
    peek(5'd2, d3);
    checks++;
    if (done_cnt != d0 || d1 !== 32'h1111_1111 ||
        d2 !== 32'h4000_0000 || d3 !== 32'h4040_0000) begin
      errors++;
      $display("FAIL rmid_rf got dn=%0d rf=%h %h %h want 0 11111111 40000000 40400000",
               done_cnt - d0, d1, d2, d3);
    end
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_class();
    test_timeout();
    test_back_to_back();
    test_wb_collision();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_issue.md
Name: fp_mul_issue

Overview:
Command sequencer and FP register file sitting directly upstream and downstream of the FP multiplier. It accepts a multiply command naming two source registers and one destination register, and reads both operands from its internal 32x32-bit FP register file. It feeds the multiplier through its A and B strobe/ack handshakes, collects the product through the product handshake, and writes the product back to the destination register. It also reports completion with result classification, and recovers a hung multiplier by timeout.

Parameters:
TIMEOUT, 64, cycles allowed from command acceptance to product capture before abort (minimum 8).
CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block can accept a command
cmd_rs1  in  5  source register for operand A
cmd_rs2  in  5  source register for operand B
cmd_rd  in  5  destination register
ld_en  in  1  external register-file write (load unit)
ld_addr  in  5  external write address
ld_data  in  32  external write data
dbg_addr  in  5  read-back address
dbg_data  out  32  combinational read of rf[dbg_addr]
mul_a  out  32  operand A to multiplier
mul_a_stb  out  1  operand A valid
mul_a_ack  in  1  multiplier ready for A
mul_b  out  32  operand B to multiplier
mul_b_stb  out  1  operand B valid
mul_b_ack  in  1  multiplier ready for B
mul_z  in  32  product from multiplier
mul_z_stb  in  1  product valid
mul_z_ack  out  1  product accepted
mul_rst_n  out  1  synchronous active-low reset to multiplier
done  out  1  one-cycle completion pulse
done_rd  out  5  destination of completed op
done_data  out  32  product written back
res_nan, res_inf, res_zero  out  1 each  classification of done_data, valid with done
timeout_err  out  1  one-cycle pulse on abort

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, counter=0. done, timeout_err, done_rd and done_data are 0. Register file contents are NOT cleared. mul_rst_n = reset_n AND NOT(state==FLUSH), so the multiplier is held in reset with this block. Reset mid-operation abandons the op with no writeback.
- States: IDLE, SEND_A, SEND_B, WAIT_Z, WB, FLUSH.
- IDLE: cmd_ready=1. On an edge with cmd_valid=1, latch op_a=rf[cmd_rs1], op_b=rf[cmd_rs2] and rd=cmd_rd, then go to SEND_A and clear the counter. Operand reads use contents before any same-cycle write.
- SEND_A: mul_a_stb=1, mul_a=op_a. Transfer happens at an edge with mul_a_stb AND mul_a_ack; then go to SEND_B. If ack is not high, hold strobe and data stable.
- SEND_B: same rules with mul_b_stb, mul_b_ack and op_b; then go to WAIT_Z.
- WAIT_Z: mul_z_ack=1. At an edge with mul_z_stb=1: rf[rd]<=mul_z, capture done_data=mul_z and done_rd=rd, go to WB.
- WB: done=1 for exactly one cycle, then IDLE. cmd_ready=0 in WB, so the minimum issue interval is 5 cycles plus multiplier latency.
- All stb/ack outputs are decoded from state and are 0 in every other state. cmd_ready=1 only in IDLE.
- Classification is combinational on done_data, meaningful only while done=1:
  - nan: exp==8'hFF and mant!=0
  - inf: exp==8'hFF and mant==0
  - zero: exp==0 and mant==0
  - The sign bit is ignored.
- Timeout: the counter increments every cycle in SEND_A, SEND_B and WAIT_Z. If it reaches TIMEOUT-1 without leaving those states:
  - go to FLUSH with no writeback;
  - in FLUSH, timeout_err=1 and mul_rst_n=0 for one cycle, then IDLE.
  - Product capture on the same edge as expiry wins; the op completes normally.
- Register-file writes:
  - Writeback (WAIT_Z capture) and ld_en write on the same edge to different addresses: both commit.
  - Same address: writeback wins and ld_data is dropped.
  - ld_en is accepted in every state, including reset.
- dbg_data shows registered contents; no bypass of same-cycle writes.

Test Plan:
- Preload rf[1]=0x40000000 (2.0) and rf[2]=0x40400000 (3.0); issue rs1=1, rs2=2, rd=3 with the real multiplier -> mul_a then mul_b transferred once each, one done pulse, done_data=rf[3]=0x40C00000, all flags 0.
- Preload rf[4]=0x7F800000 (inf) and rf[5]=0x3F800000 (1.0); issue rs1=4, rs2=5, rd=6 with a model returning 0x7F800000 -> res_inf=1, res_nan=0, res_zero=0. Then return 0x7FC00000 -> res_nan=1. Then return 0x80000000 -> res_zero=1.
- Model never asserts mul_b_ack, TIMEOUT=16 -> timeout_err pulses once 16 cycles after acceptance, mul_rst_n low exactly that cycle, rf[rd] unchanged, cmd_ready=1 on the next cycle.
- Model with randomized ack/stb delays of 0-5 cycles for four back-to-back commands -> operands stable while strobed, four done pulses in order, correct done_rd each time.
- On the WAIT_Z capture edge, drive ld_en=1 with ld_addr=rd and ld_data=0x12345678 -> rf[rd] holds the product. Repeat with ld_addr!=rd -> both registers updated.
- Assert reset_n=0 for one cycle while in WAIT_Z -> state IDLE, no done pulse, mul_rst_n=0 that cycle, register file retains preloaded values.
